piso_stream: RTL and testbench

//  Parametrised parallel-in/serial-out shifter with valid/ready load handshake.

---
 rtl/piso_stream_if.sv | 26 ++
 rtl/piso_stream.sv | 148 ++++++++++++++
 tb/tb_piso_stream.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/piso_stream_if.sv
// Load handshake and serial output bundle for piso_stream.
interface piso_stream_if #(
  parameter int unsigned WIDTH = 8
) ();
  logic [WIDTH-1:0] in_data;
  logic             in_valid;
  logic             in_ready;
  logic             msb_first;
  logic             shift_en;
  logic             out_bit;
  logic             out_valid;
  logic             out_last;
  logic             busy;

  // Upstream source / line driver side.
  modport master (
    output in_data, in_valid, msb_first, shift_en,
    input  in_ready, out_bit, out_valid, out_last, busy
  );

  // Serialiser side.
  modport slave (
    input  in_data, in_valid, msb_first, shift_en,
    output in_ready, out_bit, out_valid, out_last, busy
  );
endinterface

// File: rtl/piso_stream.sv
// Parallel-in/serial-out shifter with valid/ready load, per-word bit order and frame-last flag.
// Optional even-parity trailer bit when PISO_PARITY_EN is defined.
module piso_stream #(
  parameter int unsigned WIDTH = 8
) (
  input  logic         clk,
  input  logic         rst,
  piso_stream_if.slave bus
);

  localparam int unsigned CNT_W = $clog2(WIDTH + 2);
`ifdef PISO_PARITY_EN
  localparam int unsigned FRAME = WIDTH + 1;
`else
  localparam int unsigned FRAME = WIDTH;
`endif

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   sreg_q, sreg_d;
  logic               order_q, order_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               out_bit_q, out_bit_d;
  logic               out_valid_q, out_valid_d;
  logic               out_last_q, out_last_d;
  logic               busy_q, busy_d;
`ifdef PISO_PARITY_EN
  logic               parity_q, parity_d;
`endif
  logic               in_ready_c;
  logic               load_c;

  // Bit currently at the head of the register for the given order.
  function automatic logic head(input logic [WIDTH-1:0] v, input logic msb);
    return msb ? v[WIDTH-1] : v[0];
  endfunction

  // Drop the head bit; vacated positions fill with zero.
  function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] v, input logic msb);
    return msb ? (v << 1) : (v >> 1);
  endfunction

  // Accept a word when idle, or on the final bit's advancing edge for zero-bubble chaining.
  always_comb begin
    in_ready_c = rst & ((state_q == IDLE) |
                        ((state_q == SHIFT) & out_last_q & bus.shift_en));
    load_c     = bus.in_valid & in_ready_c;
  end

  always_comb begin
    state_d     = state_q;
    sreg_d      = sreg_q;
    order_d     = order_q;
    cnt_d       = cnt_q;
    out_bit_d   = out_bit_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    busy_d      = busy_q;
`ifdef PISO_PARITY_EN
    parity_d    = parity_q;
`endif

    case (state_q)
      IDLE: begin
        out_bit_d   = 1'b0;
        out_valid_d = 1'b0;
        out_last_d  = 1'b0;
        busy_d      = 1'b0;
      end
      SHIFT: begin
        if (bus.shift_en) begin
          if (cnt_q == '0) begin
            state_d     = IDLE;
            sreg_d      = '0;
            out_bit_d   = 1'b0;
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
            busy_d      = 1'b0;
          end else begin
            cnt_d      = cnt_q - CNT_W'(1);
            out_last_d = (cnt_q == CNT_W'(1));
            sreg_d     = advance(sreg_q, order_q);
`ifdef PISO_PARITY_EN
            out_bit_d  = (cnt_q == CNT_W'(1)) ? parity_q : head(sreg_d, order_q);
`else
            out_bit_d  = head(sreg_d, order_q);
`endif
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // A load (idle or chained at frame end) overrides the frame-end / hold decisions.
    if (load_c) begin
      state_d     = SHIFT;
      sreg_d      = bus.in_data;
      order_d     = bus.msb_first;
      cnt_d       = CNT_W'(FRAME - 1);
      out_bit_d   = head(bus.in_data, bus.msb_first);
      out_valid_d = 1'b1;
      out_last_d  = 1'b0;
      busy_d      = 1'b1;
`ifdef PISO_PARITY_EN
      parity_d    = ^bus.in_data;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      sreg_q      <= '0;
      order_q     <= 1'b0;
      cnt_q       <= '0;
      out_bit_q   <= 1'b0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      busy_q      <= 1'b0;
`ifdef PISO_PARITY_EN
      parity_q    <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      sreg_q      <= sreg_d;
      order_q     <= order_d;
      cnt_q       <= cnt_d;
      out_bit_q   <= out_bit_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      busy_q      <= busy_d;
`ifdef PISO_PARITY_EN
      parity_q    <= parity_d;
`endif
    end
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.out_bit   = out_bit_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_last  = out_last_q;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_piso_stream.sv
// Self-checking bench for piso_stream: table-driven frames plus stall, back-to-back and reset cases.
module tb_piso_stream;

  localparam int unsigned WIDTH = 8;
`ifdef PISO_PARITY_EN
  localparam bit PAR   = 1'b1;
  localparam int FRAME = 9;
`else
  localparam bit PAR   = 1'b0;
  localparam int FRAME = 8;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  piso_stream_if #(.WIDTH(WIDTH)) bus ();
  piso_stream #(.WIDTH(WIDTH)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct packed {
    logic b;
    logic last;
  } exp_t;

  typedef struct {
    logic [7:0] data;
    logic       msb;
    logic [7:0] seq;   // bit i = i-th emitted data bit
    logic       par;
  } vec_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  // Scoreboard: a bit is consumed on each cycle where it is valid and will advance.
  always @(negedge clk) begin
    if (rst === 1'b1) begin
      if (bus.out_valid === 1'b1 && bus.shift_en === 1'b1) begin
        if (sb_q.size() == 0) begin
          check("sb_underflow", 64'(1), 64'(0));
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          check("out_bit", 64'(bus.out_bit), 64'(e.b));
          check("out_last", 64'(bus.out_last), 64'(e.last));
        end
      end else if (bus.out_valid === 1'b0) begin
        check("last_when_invalid", 64'(bus.out_last), 64'(0));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] order_seq(logic [7:0] d, logic msb);
    logic [7:0] s;
    for (int i = 0; i < 8; i++) s[i] = msb ? d[7-i] : d[i];
    return s;
  endfunction

  task automatic push_frame(logic [7:0] seq, logic par);
    for (int i = 0; i < 8; i++) sb_q.push_back('{b: seq[i], last: (i == 7) && !PAR});
    if (PAR) sb_q.push_back('{b: par, last: 1'b1});
  endtask

  // Present a word, wait (bounded) for acceptance, drop valid after the load edge.
  task automatic load(logic [7:0] d, logic msb, logic [7:0] seq, logic par);
    int n;
    n = 0;
    while (bus.in_ready !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    if (n == 50) check("load_timeout", 64'(0), 64'(1));
    bus.in_data   = d;
    bus.msb_first = msb;
    bus.in_valid  = 1'b1;
    push_frame(seq, par);
    tick();
    bus.in_valid  = 1'b0;
  endtask

  task automatic frame_len(int exp, string name);
    int n;
    n = 0;
    while (bus.busy === 1'b1 && n < 100) begin
      n++;
      tick();
    end
    check(name, 64'(n), 64'(exp));
    check("valid_after_frame", 64'(bus.out_valid), 64'(0));
    check("sb_empty", 64'(sb_q.size()), 64'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    vec_t vecs[12];
    int   n;
    vecs[0]  = '{8'hB4, 1'b0, 8'hB4, 1'b0};
    vecs[1]  = '{8'hB4, 1'b1, 8'h2D, 1'b0};
    vecs[2]  = '{8'hA5, 1'b0, 8'hA5, 1'b0};
    vecs[3]  = '{8'hA5, 1'b1, 8'hA5, 1'b0};
    vecs[4]  = '{8'h0F, 1'b0, 8'h0F, 1'b0};
    vecs[5]  = '{8'h0F, 1'b1, 8'hF0, 1'b0};
    vecs[6]  = '{8'hB5, 1'b0, 8'hB5, 1'b1};
    vecs[7]  = '{8'h01, 1'b1, 8'h80, 1'b1};
    vecs[8]  = '{8'h80, 1'b0, 8'h80, 1'b1};
    vecs[9]  = '{8'hFF, 1'b1, 8'hFF, 1'b0};
    vecs[10] = '{8'h3C, 1'b1, 8'h3C, 1'b0};
    vecs[11] = '{8'hC1, 1'b1, 8'h83, 1'b1};

    bus.in_data   = '0;
    bus.in_valid  = 1'b0;
    bus.msb_first = 1'b0;
    bus.shift_en  = 1'b1;

    // Reset state
    #1 rst = 1'b0;
    #1;
    check("rst_in_ready", 64'(bus.in_ready), 64'(0));
    check("rst_out_valid", 64'(bus.out_valid), 64'(0));
    check("rst_out_bit", 64'(bus.out_bit), 64'(0));
    check("rst_busy", 64'(bus.busy), 64'(0));
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check("idle_in_ready", 64'(bus.in_ready), 64'(1));

    // Table-driven frames at full rate
    for (int i = 0; i < 12; i++) begin
      load(vecs[i].data, vecs[i].msb, vecs[i].seq, vecs[i].par);
      frame_len(FRAME, "frame_len");
    end

    // Stall: 8'hA5 LSB first, shift_en low for 3 cycles while bit 2 is shown
    load(8'hA5, 1'b0, 8'hA5, 1'b0);
    tick();
    tick();
    for (int k = 0; k < 4; k++) begin
      bus.shift_en = (k == 3);
      check("stall_bit", 64'(bus.out_bit), 64'(1));
      check("stall_valid", 64'(bus.out_valid), 64'(1));
      check("stall_ready", 64'(bus.in_ready), 64'(0));
      tick();
    end
    frame_len(FRAME - 3, "stall_frame_len");

    // Back-to-back: 8'h0F then 8'hF0 with in_valid held high
    bus.in_data   = 8'h0F;
    bus.msb_first = 1'b0;
    bus.in_valid  = 1'b1;
    push_frame(order_seq(8'h0F, 1'b0), ^8'h0F);
    check("b2b_first_ready", 64'(bus.in_ready), 64'(1));
    tick();
    bus.in_data = 8'hF0;
    push_frame(order_seq(8'hF0, 1'b0), ^8'hF0);
    n = 1;
    while (bus.in_ready !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    check("b2b_ready_cycle", 64'(n), 64'(FRAME));
    check("b2b_busy", 64'(bus.busy), 64'(1));
    tick();
    bus.in_valid = 1'b0;
    frame_len(FRAME, "b2b_second_len");

    // Reset mid-frame after bit 4
    load(8'hB4, 1'b0, 8'hB4, 1'b0);
    repeat (4) tick();
    rst = 1'b0;
    sb_q.delete();
    #1;
    check("abort_out_valid", 64'(bus.out_valid), 64'(0));
    check("abort_out_bit", 64'(bus.out_bit), 64'(0));
    check("abort_busy", 64'(bus.busy), 64'(0));
    check("abort_in_ready", 64'(bus.in_ready), 64'(0));
    tick();
    tick();
    rst = 1'b1;
    #1;
    check("release_in_ready", 64'(bus.in_ready), 64'(1));
    check("release_busy", 64'(bus.busy), 64'(0));
    load(8'h3C, 1'b1, order_seq(8'h3C, 1'b1), ^8'h3C);
    frame_len(FRAME, "post_reset_len");

    tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
